// File: rtl/x86_modrm_decode_if.sv
// Bus between the fetch/execute side and the ModRM/SIB/displacement decoder.
// Signal names follow the decoder's port list; dbg_state exposes the FSM state.
interface x86_modrm_decode_if;
  logic         locked;
  logic         start;
  logic         adsize;
  logic         seg_of;
  logic [2:0]   seg_of_id;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_take;
  logic [255:0] gpr;
  logic         busy;
  logic         done;
  logic [1:0]   mod_o;
  logic [2:0]   reg_o;
  logic [2:0]   rm_o;
  logic         is_mem;
  logic [31:0]  ea;
  logic [2:0]   ea_seg;
  logic [2:0]   len;
  logic [2:0]   dbg_state;

  // Handshake: a byte is consumed in a cycle exactly when byte_take=1, which
  // requires byte_valid=1 from the master; the master holds byte_in until taken.
  modport master (
    output locked, start, adsize, seg_of, seg_of_id, byte_in, byte_valid, gpr,
    input  byte_take, busy, done, mod_o, reg_o, rm_o, is_mem, ea, ea_seg, len,
           dbg_state
  );

  modport slave (
    input  locked, start, adsize, seg_of, seg_of_id, byte_in, byte_valid, gpr,
    output byte_take, busy, done, mod_o, reg_o, rm_o, is_mem, ea, ea_seg, len,
           dbg_state
  );
endinterface

// File: rtl/x86_modrm_decode.sv
// Decodes ModRM, optional SIB and displacement bytes into mod/reg/rm fields,
// an effective offset and an effective segment for the execute stage.
module x86_modrm_decode #(
  parameter logic [2:0] SEG_DS = 3'd3,
  parameter logic [2:0] SEG_SS = 3'd2
) (
  input logic           clock,
  input logic           reset_n,
  x86_modrm_decode_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MODRM = 3'd1;
  localparam logic [2:0] S_SIB   = 3'd2;
  localparam logic [2:0] S_DISP  = 3'd3;
  localparam logic [2:0] S_CALC  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic        adsize_q, adsize_d;
  logic        seg_of_q, seg_of_d;
  logic [2:0]  seg_id_q, seg_id_d;
  logic [7:0]  modrm_q, modrm_d;
  logic [7:0]  sib_q, sib_d;
  logic        has_sib_q, has_sib_d;
  logic [31:0] disp_q, disp_d;
  logic [2:0]  disp_n_q, disp_n_d;
  logic [2:0]  disp_idx_q, disp_idx_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  mod_q, mod_d;
  logic [2:0]  reg_q, reg_d;
  logic [2:0]  rm_q, rm_d;
  logic        is_mem_q, is_mem_d;
  logic [31:0] ea_q, ea_d;
  logic [2:0]  ea_seg_q, ea_seg_d;
  logic [2:0]  len_q, len_d;

  logic        byte_state;
  logic        take;
  logic [2:0]  n_modrm;
  logic [2:0]  n_sib;
  logic [31:0] ea_calc;
  logic [2:0]  seg_calc;

  logic [255:0] gpr_w;
  logic [15:0]  bx16, bp16, si16, di16;

  assign gpr_w = bus.gpr;
  assign bx16  = gpr_w[3*32 +: 16];
  assign bp16  = gpr_w[5*32 +: 16];
  assign si16  = gpr_w[6*32 +: 16];
  assign di16  = gpr_w[7*32 +: 16];

  function automatic logic [31:0] gpr_sel(input logic [255:0] g, input logic [2:0] i);
    return g[{i, 5'b00000} +: 32];
  endfunction

  // Displacement length implied by mod/rm (and SIB.base in 32-bit mode).
  function automatic logic [2:0] disp_count(input logic a32, input logic [1:0] md,
                                            input logic [2:0] rmf, input logic sib,
                                            input logic [2:0] base);
    logic [2:0] n;
    n = 3'd0;
    case (md)
      2'd1: n = 3'd1;
      2'd2: n = a32 ? 3'd4 : 3'd2;
      2'd0: begin
        if (!a32)     n = (rmf == 3'd6)  ? 3'd2 : 3'd0;
        else if (sib) n = (base == 3'd5) ? 3'd4 : 3'd0;
        else          n = (rmf == 3'd5)  ? 3'd4 : 3'd0;
      end
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  assign byte_state = (state_q == S_MODRM) || (state_q == S_SIB) || (state_q == S_DISP);
  assign take       = byte_state & bus.byte_valid & bus.locked;
  assign n_modrm    = disp_count(adsize_q, bus.byte_in[7:6], bus.byte_in[2:0], 1'b0, 3'd0);
  assign n_sib      = disp_count(1'b1, modrm_q[7:6], modrm_q[2:0], 1'b1, bus.byte_in[2:0]);

  // Effective address from the latched bytes and the live register file.
  always_comb begin
    logic [1:0]  cur_mod;
    logic [2:0]  cur_rm;
    logic [31:0] disp_ext;
    logic [31:0] base_val;
    logic [31:0] index_val;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [2:0]  base_reg;
    logic        base_used;
    logic        use_ss;
    cur_mod   = modrm_q[7:6];
    cur_rm    = modrm_q[2:0];
    disp_ext  = 32'd0;
    base_val  = 32'd0;
    index_val = 32'd0;
    a16       = 16'd0;
    b16       = 16'd0;
    base_reg  = 3'd0;
    base_used = 1'b0;
    use_ss    = 1'b0;
    ea_calc   = 32'd0;
    case (disp_n_q)
      3'd1:    disp_ext = {{24{disp_q[7]}}, disp_q[7:0]};
      3'd2:    disp_ext = {16'd0, disp_q[15:0]};
      3'd4:    disp_ext = disp_q;
      default: disp_ext = 32'd0;
    endcase
    if (cur_mod == 2'd3) begin
      ea_calc = 32'd0;
    end else if (!adsize_q) begin
      case (cur_rm)
        3'd0: begin a16 = bx16; b16 = si16; end
        3'd1: begin a16 = bx16; b16 = di16; end
        3'd2: begin a16 = bp16; b16 = si16; use_ss = 1'b1; end
        3'd3: begin a16 = bp16; b16 = di16; use_ss = 1'b1; end
        3'd4: a16 = si16;
        3'd5: a16 = di16;
        3'd6: if (cur_mod != 2'd0) begin a16 = bp16; use_ss = 1'b1; end
        default: a16 = bx16;
      endcase
      ea_calc = {16'd0, a16 + b16 + disp_ext[15:0]};
    end else if (has_sib_q) begin
      base_reg  = sib_q[2:0];
      base_used = !((base_reg == 3'd5) && (cur_mod == 2'd0));
      base_val  = base_used ? gpr_sel(gpr_w, base_reg) : 32'd0;
      index_val = (sib_q[5:3] == 3'd4) ? 32'd0 : (gpr_sel(gpr_w, sib_q[5:3]) << sib_q[7:6]);
      use_ss    = base_used && ((base_reg == 3'd4) || (base_reg == 3'd5));
      ea_calc   = base_val + index_val + disp_ext;
    end else begin
      base_used = !((cur_mod == 2'd0) && (cur_rm == 3'd5));
      base_val  = base_used ? gpr_sel(gpr_w, cur_rm) : 32'd0;
      use_ss    = base_used && ((cur_rm == 3'd4) || (cur_rm == 3'd5));
      ea_calc   = base_val + disp_ext;
    end
    seg_calc = seg_of_q ? seg_id_q : (use_ss ? SEG_SS : SEG_DS);
  end

  always_comb begin
    state_d    = state_q;
    adsize_d   = adsize_q;
    seg_of_d   = seg_of_q;
    seg_id_d   = seg_id_q;
    modrm_d    = modrm_q;
    sib_d      = sib_q;
    has_sib_d  = has_sib_q;
    disp_d     = disp_q;
    disp_n_d   = disp_n_q;
    disp_idx_d = disp_idx_q;
    cnt_d      = cnt_q;
    mod_d      = mod_q;
    reg_d      = reg_q;
    rm_d       = rm_q;
    is_mem_d   = is_mem_q;
    ea_d       = ea_q;
    ea_seg_d   = ea_seg_q;
    len_d      = len_q;
    // locked=0 freezes everything, including a pending DONE.
    if (bus.locked) begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            adsize_d   = bus.adsize;
            seg_of_d   = bus.seg_of;
            seg_id_d   = bus.seg_of_id;
            cnt_d      = 3'd0;
            has_sib_d  = 1'b0;
            disp_d     = 32'd0;
            disp_n_d   = 3'd0;
            disp_idx_d = 3'd0;
            state_d    = S_MODRM;
          end
        end
        S_MODRM: begin
          if (take) begin
            modrm_d = bus.byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (bus.byte_in[7:6] == 2'd3) begin
              disp_n_d = 3'd0;
              state_d  = S_CALC;
            end else if (adsize_q && (bus.byte_in[2:0] == 3'd4)) begin
              has_sib_d = 1'b1;
              state_d   = S_SIB;
            end else begin
              disp_n_d = n_modrm;
              state_d  = (n_modrm == 3'd0) ? S_CALC : S_DISP;
            end
          end
        end
        S_SIB: begin
          if (take) begin
            sib_d    = bus.byte_in;
            cnt_d    = cnt_q + 3'd1;
            disp_n_d = n_sib;
            state_d  = (n_sib == 3'd0) ? S_CALC : S_DISP;
          end
        end
        S_DISP: begin
          if (take) begin
            disp_d[{disp_idx_q[1:0], 3'b000} +: 8] = bus.byte_in;
            disp_idx_d = disp_idx_q + 3'd1;
            cnt_d      = cnt_q + 3'd1;
            if ((disp_idx_q + 3'd1) == disp_n_q) state_d = S_CALC;
          end
        end
        S_CALC: begin
          mod_d    = modrm_q[7:6];
          reg_d    = modrm_q[5:3];
          rm_d     = modrm_q[2:0];
          is_mem_d = (modrm_q[7:6] != 2'd3);
          ea_d     = ea_calc;
          ea_seg_d = seg_calc;
          len_d    = cnt_q;
          state_d  = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      adsize_q   <= 1'b0;
      seg_of_q   <= 1'b0;
      seg_id_q   <= 3'd0;
      modrm_q    <= 8'd0;
      sib_q      <= 8'd0;
      has_sib_q  <= 1'b0;
      disp_q     <= 32'd0;
      disp_n_q   <= 3'd0;
      disp_idx_q <= 3'd0;
      cnt_q      <= 3'd0;
      mod_q      <= 2'd0;
      reg_q      <= 3'd0;
      rm_q       <= 3'd0;
      is_mem_q   <= 1'b0;
      ea_q       <= 32'd0;
      ea_seg_q   <= 3'd0;
      len_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      adsize_q   <= adsize_d;
      seg_of_q   <= seg_of_d;
      seg_id_q   <= seg_id_d;
      modrm_q    <= modrm_d;
      sib_q      <= sib_d;
      has_sib_q  <= has_sib_d;
      disp_q     <= disp_d;
      disp_n_q   <= disp_n_d;
      disp_idx_q <= disp_idx_d;
      cnt_q      <= cnt_d;
      mod_q      <= mod_d;
      reg_q      <= reg_d;
      rm_q       <= rm_d;
      is_mem_q   <= is_mem_d;
      ea_q       <= ea_d;
      ea_seg_q   <= ea_seg_d;
      len_q      <= len_d;
    end
  end

  assign bus.byte_take = take;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.mod_o     = mod_q;
  assign bus.reg_o     = reg_q;
  assign bus.rm_o      = rm_q;
  assign bus.is_mem    = is_mem_q;
  assign bus.ea        = ea_q;
  assign bus.ea_seg    = ea_seg_q;
  assign bus.len       = len_q;
  assign bus.dbg_state = state_q;

endmodule
